if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
Parametrised successor to the single-register IF/ID pipeline stage. It sits between the fetch side (ROM output plus PC) and decoInst. It holds up to DEPTH fetched instruction/PC pairs in a circular buffer, with valid/ready handshakes on both sides and a synchronous flush for branch redirects. It replaces the one-entry, always-advancing register so that decode can stall without losing fetched instructions.

Parameters:
INST_W, 26, instruction width in bits
PC_W, 16, program counter width in bits
DEPTH, 2, number of buffer entries; must be a power of two and at least 2
NOP_INST, 0 (INST_W bits), value driven on out_inst when the buffer is empty and loaded into entries at reset

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; discards all entries
in_valid  in  1  fetch side presents in_inst/in_pc
in_ready  out  1  buffer can accept an entry this cycle
in_inst  in  INST_W  fetched instruction
in_pc  in  PC_W  PC of the fetched instruction
out_valid  out  1  head entry valid toward decode
out_ready  in  1  decode consumes the head entry this cycle
out_inst  out  INST_W  head instruction to decoInst
out_pc  out  PC_W  head PC
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All entries set to NOP_INST/0.
  - out_valid=0, out_inst=NOP_INST, out_pc=0, in_ready=1.
  - Deassertion is sampled at the next rising edge.
- Push: accepted when in_valid=1 and in_ready=1 at a rising edge.
  - The entry is written at wr_ptr, and wr_ptr advances.
- Pop: occurs when out_valid=1 and out_ready=1 at a rising edge.
  - rd_ptr advances.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH naturally.
- count update per edge: +1 on push only, -1 on pop only, unchanged on push+pop.
- Output and ready decoding (registered state only, no combinational input-to-output paths):
  - in_ready = (count < DEPTH). It does not depend on out_ready, so a full buffer rejects a push even while popping; there is no pass-through.
  - out_valid = (count != 0).
  - out_inst/out_pc = entry[rd_ptr] when count != 0, else NOP_INST/0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle), matching the previous IF/ID stage.
- Throughput: with out_ready held at 1, one entry per cycle is sustained and count stays at 1.
- Flush: highest priority among synchronous events.
  - At an edge with flush=1: count=0, wr_ptr=rd_ptr=0.
  - Any simultaneous push is discarded and no pop is counted.
  - Entry contents need not be cleared.
- Full/empty boundaries:
  - Full: in_valid with in_ready=0 has no effect; the source holds its data.
  - Empty: out_ready is ignored.
- Reset mid-operation: all entries are lost and the outputs return to reset values immediately.

Test Plan:
- Reset: load 2 entries, drive rst=0 between edges → same time step: out_valid=0, out_inst=26'h0, out_pc=16'h0, count=0, in_ready=1.
- Streaming: out_ready=1, push pc 0..5 with inst 26'h1..26'h6 on consecutive edges → out_pc follows one cycle later in order 0..5, count=1 throughout, no stalls.
- Backpressure: out_ready=0, push pc 16'h10 and 16'h11 → count=2, in_ready=0; pc 16'h12 held on the inputs is not accepted. Raise out_ready → outputs 16'h10, 16'h11, then 16'h12 after it is accepted.
- Full with simultaneous pop: count=2, in_valid=1, out_ready=1 → head popped, no push, count=1. The next edge pushes, and count stays 1.
- Flush with push: count=2, flush=1 with in_valid=1, pc 16'h20 → after the edge count=0, out_valid=0, out_inst=NOP. 16'h20 never appears on the outputs.
- Wrap-around (DEPTH=4): push pc 0..9 with out_ready pseudo-random (1,0,0,1,1,0,1,…) → all 10 PCs emerge in order, count never exceeds 4, no duplicates or drops across pointer wrap.

Source files
------------

// File: rtl/if_id_buffer_if.sv
// Handshake bundle between fetch, the IF/ID buffer and decode.
// The master modport is the fetch/decode side; the slave modport is the buffer.
interface if_id_buffer_if #(
    parameter int INST_W = 26,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 2
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [INST_W-1:0]          in_inst;
    logic [PC_W-1:0]            in_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [INST_W-1:0]          out_inst;
    logic [PC_W-1:0]            out_pc;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, count
    );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID circular buffer: holds up to DEPTH fetched instruction/PC pairs so decode can stall
// without dropping fetches; flush discards everything on a branch redirect.
module if_id_buffer #(
    parameter int                INST_W   = 26,
    parameter int                PC_W     = 16,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic            clk,
    input  logic            rst,
    if_id_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INST_W-1:0] r_inst [DEPTH];
    logic [PC_W-1:0]   r_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready/valid come only from registered occupancy, so a full buffer refuses a push even while popping.
    assign w_in_ready  = (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= NOP_INST;
                r_pc[i]   <= '0;
            end
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_inst[r_wr_ptr] <= bus.in_inst;
                r_pc[r_wr_ptr]   <= bus.in_pc;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_inst  = w_out_valid ? r_inst[r_rd_ptr] : NOP_INST;
    assign bus.out_pc    = w_out_valid ? r_pc[r_rd_ptr] : '0;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a DEPTH=2 instance for the directed cases and a
// DEPTH=4 instance for pointer wrap-around.
module tb_if_id_buffer;
    logic clk;
    logic rst;
    logic acc;
    int   checks;
    int   errors;

    logic [41:0] q2[$];
    logic [41:0] q4[$];

    if_id_buffer_if #(.INST_W(26), .PC_W(16), .DEPTH(2)) bus2 ();
    if_id_buffer_if #(.INST_W(26), .PC_W(16), .DEPTH(4)) bus4 ();

    if_id_buffer #(.INST_W(26), .PC_W(16), .DEPTH(2), .NOP_INST(26'h0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    if_id_buffer #(.INST_W(26), .PC_W(16), .DEPTH(4), .NOP_INST(26'h0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares the DUT against a FIFO model of accepted entries, then advances the model
    // with the inputs that will be seen at the coming rising edge.
    task automatic monStep(input int which, input int depth, input logic v, input logic [25:0] ii,
                           input logic [15:0] ip, input logic ordy, input logic fl,
                           input logic inRdy, input logic outV, input logic [25:0] oi,
                           input logic [15:0] op, input logic [31:0] cnt);
        logic [41:0] head;
        int n;
        n    = (which == 2) ? q2.size() : q4.size();
        head = '0;
        if (n != 0) head = (which == 2) ? q2[0] : q4[0];
        checkOutput($sformatf("dut%0d count", which), cnt, n);
        checkOutput($sformatf("dut%0d in_ready", which), inRdy, (n < depth));
        checkOutput($sformatf("dut%0d out_valid", which), outV, (n != 0));
        checkOutput($sformatf("dut%0d out_inst", which), oi, head[41:16]);
        checkOutput($sformatf("dut%0d out_pc", which), op, head[15:0]);
        if (fl) begin
            if (which == 2) q2.delete(); else q4.delete();
        end else begin
            if (n != 0 && ordy) begin
                if (which == 2) void'(q2.pop_front()); else void'(q4.pop_front());
            end
            if (v && n < depth) begin
                if (which == 2) q2.push_back({ii, ip}); else q4.push_back({ii, ip});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            q2.delete();
            q4.delete();
        end else begin
            monStep(2, 2, bus2.in_valid, bus2.in_inst, bus2.in_pc, bus2.out_ready, bus2.flush,
                    bus2.in_ready, bus2.out_valid, bus2.out_inst, bus2.out_pc, 32'(bus2.count));
            monStep(4, 4, bus4.in_valid, bus4.in_inst, bus4.in_pc, bus4.out_ready, bus4.flush,
                    bus4.in_ready, bus4.out_valid, bus4.out_inst, bus4.out_pc, 32'(bus4.count));
        end
    end

    // Drives one cycle of inputs on the selected instance; acc reports whether the push is taken.
    task automatic applyStimulus(input int which, input logic v, input logic [25:0] inst,
                                 input logic [15:0] pc, input logic ordy, input logic fl,
                                 output logic accepted);
        if (which == 2) begin
            bus2.in_valid = v; bus2.in_inst = inst; bus2.in_pc = pc;
            bus2.out_ready = ordy; bus2.flush = fl;
            accepted = v && bus2.in_ready && !fl;
        end else begin
            bus4.in_valid = v; bus4.in_inst = inst; bus4.in_pc = pc;
            bus4.out_ready = ordy; bus4.flush = fl;
            accepted = v && bus4.in_ready && !fl;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int idx;
        int pat[7];
        checks = 0;
        errors = 0;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        rst = 1'b0;
        bus2.in_valid = 0; bus2.in_inst = '0; bus2.in_pc = '0; bus2.out_ready = 0; bus2.flush = 0;
        bus4.in_valid = 0; bus4.in_inst = '0; bus4.in_pc = '0; bus4.out_ready = 0; bus4.flush = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] streaming");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, 1'b1, 26'(i + 1), 16'(i), 1'b1, 1'b0, acc);
            checkOutput("stream count", 32'(bus2.count), 1);
            checkOutput("stream out_pc", bus2.out_pc, i);
            checkOutput("stream out_inst", bus2.out_inst, i + 1);
        end
        applyStimulus(2, 1'b0, 26'h0, 16'h0, 1'b1, 1'b0, acc);
        checkOutput("stream drained", 32'(bus2.count), 0);

        $display("[TB] backpressure and full with pop");
        applyStimulus(2, 1'b1, 26'h110, 16'h10, 1'b0, 1'b0, acc);
        applyStimulus(2, 1'b1, 26'h111, 16'h11, 1'b0, 1'b0, acc);
        checkOutput("bp count full", 32'(bus2.count), 2);
        checkOutput("bp in_ready", bus2.in_ready, 0);
        repeat (2) applyStimulus(2, 1'b1, 26'h112, 16'h12, 1'b0, 1'b0, acc);
        checkOutput("bp held head", bus2.out_pc, 16'h10);
        checkOutput("bp still full", 32'(bus2.count), 2);
        applyStimulus(2, 1'b1, 26'h112, 16'h12, 1'b1, 1'b0, acc);
        checkOutput("full pop count", 32'(bus2.count), 1);
        checkOutput("full pop head", bus2.out_pc, 16'h11);
        applyStimulus(2, 1'b1, 26'h112, 16'h12, 1'b1, 1'b0, acc);
        checkOutput("push pop count", 32'(bus2.count), 1);
        checkOutput("push pop head", bus2.out_pc, 16'h12);
        checkOutput("push pop inst", bus2.out_inst, 26'h112);
        applyStimulus(2, 1'b0, 26'h0, 16'h0, 1'b1, 1'b0, acc);
        checkOutput("bp drained", 32'(bus2.count), 0);

        $display("[TB] flush");
        applyStimulus(2, 1'b1, 26'h130, 16'h30, 1'b0, 1'b0, acc);
        applyStimulus(2, 1'b1, 26'h131, 16'h31, 1'b0, 1'b0, acc);
        applyStimulus(2, 1'b1, 26'h120, 16'h20, 1'b1, 1'b1, acc);
        checkOutput("flush count", 32'(bus2.count), 0);
        checkOutput("flush out_valid", bus2.out_valid, 0);
        checkOutput("flush out_inst", bus2.out_inst, 26'h0);
        applyStimulus(2, 1'b1, 26'h121, 16'h21, 1'b0, 1'b0, acc);
        checkOutput("post flush head", bus2.out_pc, 16'h21);
        checkOutput("post flush count", 32'(bus2.count), 1);
        applyStimulus(2, 1'b0, 26'h0, 16'h0, 1'b1, 1'b0, acc);

        $display("[TB] async reset");
        applyStimulus(2, 1'b1, 26'h140, 16'h40, 1'b0, 1'b0, acc);
        applyStimulus(2, 1'b1, 26'h141, 16'h41, 1'b0, 1'b0, acc);
        bus2.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset out_valid", bus2.out_valid, 0);
        checkOutput("reset out_inst", bus2.out_inst, 26'h0);
        checkOutput("reset out_pc", bus2.out_pc, 16'h0);
        checkOutput("reset count", 32'(bus2.count), 0);
        checkOutput("reset in_ready", bus2.in_ready, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] wrap-around on DEPTH=4");
        idx = 0;
        for (int c = 0; c < 80 && (idx < 10 || bus4.count != 0); c++) begin
            applyStimulus(4, (idx < 10), 26'(idx + 1), 16'(idx), pat[c % 7] != 0, 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("wrap all accepted", idx, 10);
        checkOutput("wrap drained", 32'(bus4.count), 0);
        applyStimulus(4, 1'b0, 26'h0, 16'h0, 1'b0, 1'b0, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
